switch_debounce: RTL



---
 rtl/switch_debounce_if.sv | 24 ++
 rtl/switch_debounce.sv | 110 +++++++++++
 2 files changed

// File: rtl/switch_debounce_if.sv
// Switch-channel bundle between the raw button pins and the debouncer outputs.
// The slave side is the conditioner; the master side is whoever drives the pins.
interface switch_debounce_if #(
  parameter int NUM_SWITCHES = 4
);
  logic [NUM_SWITCHES-1:0] i_Switch;
  logic [NUM_SWITCHES-1:0] o_Switch;
  logic [NUM_SWITCHES-1:0] o_Press;
  logic [NUM_SWITCHES-1:0] o_Release;

  modport master (
    output i_Switch,
    input  o_Switch,
    input  o_Press,
    input  o_Release
  );

  modport slave (
    input  i_Switch,
    output o_Switch,
    output o_Press,
    output o_Release
  );
endinterface

// File: rtl/switch_debounce.sv
// Multi-channel switch conditioner: two-flop synchroniser, per-channel bounce filter,
// and a registered clean level with one-cycle press/release pulses.
module switch_debounce #(
  parameter int NUM_SWITCHES   = 4,
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  switch_debounce_if.slave     bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    STABLE,
    COUNTING
  } state_t;

  logic [NUM_SWITCHES-1:0] s1_q;
  logic [NUM_SWITCHES-1:0] s2_q;
  logic [NUM_SWITCHES-1:0] out_q,   out_d;
  logic [NUM_SWITCHES-1:0] press_q, press_d;
  logic [NUM_SWITCHES-1:0] rel_q,   rel_d;
  logic [NUM_SWITCHES-1:0] diff;

  state_t           state_q [NUM_SWITCHES];
  state_t           state_d [NUM_SWITCHES];
  logic [CNT_W-1:0] cnt_q   [NUM_SWITCHES];
  logic [CNT_W-1:0] cnt_d   [NUM_SWITCHES];

  assign diff = s2_q ^ out_q;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      s1_q    <= '0;
      s2_q    <= '0;
      out_q   <= '0;
      press_q <= '0;
      rel_q   <= '0;
      for (int n = 0; n < NUM_SWITCHES; n++) begin
        state_q[n] <= STABLE;
        cnt_q[n]   <= '0;
      end
    end else begin
      s1_q    <= bus.i_Switch;
      s2_q    <= s1_q;
      out_q   <= out_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      for (int n = 0; n < NUM_SWITCHES; n++) begin
        state_q[n] <= state_d[n];
        cnt_q[n]   <= cnt_d[n];
      end
    end
  end

  // In STABLE the counter is 0, so comparing it to CNT_LAST also covers DEBOUNCE_LIMIT=1.
  always_comb begin
    out_d   = out_q;
    press_d = '0;
    rel_d   = '0;
    for (int n = 0; n < NUM_SWITCHES; n++) begin
      state_d[n] = state_q[n];
      cnt_d[n]   = cnt_q[n];
      case (state_q[n])
        STABLE: begin
          if (diff[n]) begin
            if (cnt_q[n] == CNT_LAST) begin
              out_d[n]   = s2_q[n];
              press_d[n] = s2_q[n];
              rel_d[n]   = ~s2_q[n];
              cnt_d[n]   = '0;
              state_d[n] = STABLE;
            end else begin
              cnt_d[n]   = cnt_q[n] + CNT_ONE;
              state_d[n] = COUNTING;
            end
          end else begin
            cnt_d[n] = '0;
          end
        end
        COUNTING: begin
          if (!diff[n]) begin
            cnt_d[n]   = '0;
            state_d[n] = STABLE;
          end else if (cnt_q[n] == CNT_LAST) begin
            out_d[n]   = s2_q[n];
            press_d[n] = s2_q[n];
            rel_d[n]   = ~s2_q[n];
            cnt_d[n]   = '0;
            state_d[n] = STABLE;
          end else begin
            cnt_d[n] = cnt_q[n] + CNT_ONE;
          end
        end
        default: begin
          cnt_d[n]   = '0;
          state_d[n] = STABLE;
        end
      endcase
    end
  end

  assign bus.o_Switch  = out_q;
  assign bus.o_Press   = press_q;
  assign bus.o_Release = rel_q;

endmodule
